// File: rtl/rv32i_defs.sv
// Shared RV32I definitions: opcodes, immediate formats and the canonical NOP.
// The ALU and later pipeline stages import this package as well.
package rv32i_defs;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_REG:                    return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      default:                   return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, with same-cycle write-to-read forwarding.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];
  logic        wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding covers a writeback landing in the same cycle as the read.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) rdata1 = regs[raddr1];
    if (wr_en && (waddr == raddr1)) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) rdata2 = regs[raddr2];
    if (wr_en && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: fetch/decode pipeline register, field extraction,
// immediate formatting and register file reads.
module decode
  import rv32i_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_INST,
  input  logic        F_VALID,
  input  logic        W_VALID,
  input  logic [4:0]  W_REG_D,
  input  logic [31:0] W_REG_D_V,
  output logic [31:0] D_PC,
  output logic [31:0] D_INST,
  output logic        D_VALID,
  output logic [6:0]  D_OPCODE,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [31:0] D_IMM,
  output logic [4:0]  D_REG_D,
  output logic [4:0]  D_REG_S1,
  output logic [31:0] D_REG_S1_V,
  output logic [4:0]  D_REG_S2,
  output logic [31:0] D_REG_S2_V
);

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  fmt_e        fmt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (FLUSH) begin
      pc_q    <= F_PC;
      inst_q  <= F_INST;
      valid_q <= 1'b0;
    end else if (!STALL) begin
      pc_q    <= F_PC;
      inst_q  <= F_INST;
      valid_q <= F_VALID;
    end
  end

  assign D_PC     = pc_q;
  assign D_INST   = inst_q;
  assign D_VALID  = valid_q;
  assign D_OPCODE = inst_q[6:0];
  assign D_FUNCT3 = inst_q[14:12];
  assign D_FUNCT7 = inst_q[31:25];

  assign fmt = fmt_of(inst_q[6:0]);

  always_comb begin
    D_IMM    = '0;
    D_REG_D  = inst_q[11:7];
    D_REG_S1 = inst_q[19:15];
    D_REG_S2 = inst_q[24:20];
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        D_IMM    = {{20{inst_q[31]}}, inst_q[31:20]};
        D_REG_S2 = '0;
      end
      FMT_S: begin
        D_IMM   = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
        D_REG_D = '0;
      end
      FMT_B: begin
        D_IMM   = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                   inst_q[11:8], 1'b0};
        D_REG_D = '0;
      end
      FMT_U: begin
        D_IMM    = {inst_q[31:12], 12'b0};
        D_REG_S1 = '0;
        D_REG_S2 = '0;
      end
      FMT_J: begin
        D_IMM    = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                    inst_q[30:21], 1'b0};
        D_REG_S1 = '0;
        D_REG_S2 = '0;
      end
      default: begin
        D_REG_D  = '0;
        D_REG_S1 = '0;
        D_REG_S2 = '0;
      end
    endcase
  end

  // Reads use the gated indices so absent operands always come back as zero.
  regfile u_regfile (
    .clk    (CLK),
    .rst_n  (RST),
    .we     (W_VALID),
    .waddr  (W_REG_D),
    .wdata  (W_REG_D_V),
    .raddr1 (D_REG_S1),
    .raddr2 (D_REG_S2),
    .rdata1 (D_REG_S1_V),
    .rdata2 (D_REG_S2_V)
  );

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the RV32I decode stage.
module tb_decode;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, F_VALID, W_VALID;
  logic [31:0] F_PC, F_INST, W_REG_D_V;
  logic [4:0]  W_REG_D;
  logic [31:0] D_PC, D_INST, D_IMM, D_REG_S1_V, D_REG_S2_V;
  logic        D_VALID;
  logic [6:0]  D_OPCODE, D_FUNCT7;
  logic [2:0]  D_FUNCT3;
  logic [4:0]  D_REG_D, D_REG_S1, D_REG_S2;

  int errors = 0;
  int checks = 0;

  decode #(.RESET_PC(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .F_PC(F_PC), .F_INST(F_INST), .F_VALID(F_VALID),
    .W_VALID(W_VALID), .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V),
    .D_PC(D_PC), .D_INST(D_INST), .D_VALID(D_VALID),
    .D_OPCODE(D_OPCODE), .D_FUNCT3(D_FUNCT3), .D_FUNCT7(D_FUNCT7),
    .D_IMM(D_IMM), .D_REG_D(D_REG_D),
    .D_REG_S1(D_REG_S1), .D_REG_S1_V(D_REG_S1_V),
    .D_REG_S2(D_REG_S2), .D_REG_S2_V(D_REG_S2_V)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    F_VALID = 1'b1; F_PC = 32'h40; F_INST = 32'h00500093;
    W_VALID = 1'b1; W_REG_D = 5'd3; W_REG_D_V = 32'h0000FFFF;
    tick; tick;
    checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", D_VALID); end
    checks++; if (D_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", D_PC); end
    checks++; if (D_INST !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=00000000", D_INST); end
    RST = 1'b1; W_VALID = 1'b0;
    for (int r = 1; r < 32; r++) begin
      logic [4:0] rr;
      rr = r[4:0];
      F_INST = {7'b0, rr, rr, 3'b000, 5'd0, 7'b0110011};
      tick;
      checks++;
      if (D_REG_S1_V !== 32'h0 || D_REG_S2_V !== 32'h0) begin
        errors++; $display("FAIL reset_reg x%0d got=%h/%h exp=0", r, D_REG_S1_V, D_REG_S2_V);
      end
    end
  endtask

  task automatic test_addi;
    F_PC = 32'h100; F_INST = 32'h00500093; F_VALID = 1'b1;
    tick;
    checks++; if (D_OPCODE !== 7'h13) begin errors++; $display("FAIL addi_opcode got=%h exp=13", D_OPCODE); end
    checks++; if (D_REG_D !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", D_REG_D); end
    checks++; if (D_REG_S1 !== 5'd0) begin errors++; $display("FAIL addi_rs1 got=%0d exp=0", D_REG_S1); end
    checks++; if (D_REG_S1_V !== 32'h0) begin errors++; $display("FAIL addi_rs1v got=%h exp=0", D_REG_S1_V); end
    checks++; if (D_REG_S2 !== 5'd0) begin errors++; $display("FAIL addi_rs2 got=%0d exp=0", D_REG_S2); end
    checks++; if (D_IMM !== 32'h5) begin errors++; $display("FAIL addi_imm got=%h exp=00000005", D_IMM); end
    checks++; if (D_VALID !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0b exp=1", D_VALID); end
    checks++; if (D_PC !== 32'h100) begin errors++; $display("FAIL addi_pc got=%h exp=00000100", D_PC); end
    F_PC = 32'h104; F_INST = 32'hFFF08113;
    tick;
    checks++; if (D_IMM !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi2_imm got=%h exp=ffffffff", D_IMM); end
    checks++; if (D_REG_D !== 5'd2) begin errors++; $display("FAIL addi2_rd got=%0d exp=2", D_REG_D); end
    checks++; if (D_REG_S1 !== 5'd1) begin errors++; $display("FAIL addi2_rs1 got=%0d exp=1", D_REG_S1); end
    checks++; if (D_REG_S2 !== 5'd0) begin errors++; $display("FAIL addi2_rs2 got=%0d exp=0", D_REG_S2); end
  endtask

  task automatic test_store;
    F_VALID = 1'b0; F_INST = 32'h00000013;
    W_VALID = 1'b1; W_REG_D = 5'd1; W_REG_D_V = 32'h100;
    tick;
    W_REG_D = 5'd2; W_REG_D_V = 32'hAB;
    tick;
    W_VALID = 1'b0;
    F_VALID = 1'b1; F_PC = 32'h200; F_INST = 32'hFE20AE23;
    tick;
    checks++; if (D_IMM !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got=%h exp=fffffffc", D_IMM); end
    checks++; if (D_REG_D !== 5'd0) begin errors++; $display("FAIL sw_rd got=%0d exp=0", D_REG_D); end
    checks++; if (D_REG_S1_V !== 32'h100) begin errors++; $display("FAIL sw_rs1v got=%h exp=00000100", D_REG_S1_V); end
    checks++; if (D_REG_S2_V !== 32'hAB) begin errors++; $display("FAIL sw_rs2v got=%h exp=000000ab", D_REG_S2_V); end
    checks++; if (D_FUNCT3 !== 3'd2) begin errors++; $display("FAIL sw_funct3 got=%0d exp=2", D_FUNCT3); end
    checks++; if (D_FUNCT7 !== 7'h7F) begin errors++; $display("FAIL sw_funct7 got=%h exp=7f", D_FUNCT7); end
    checks++; if (D_REG_S2 !== 5'd2) begin errors++; $display("FAIL sw_rs2 got=%0d exp=2", D_REG_S2); end
  endtask

  task automatic test_bypass;
    STALL = 1'b1;
    W_VALID = 1'b1; W_REG_D = 5'd1; W_REG_D_V = 32'h12345678;
    #1;
    checks++; if (D_REG_S1_V !== 32'h12345678) begin errors++; $display("FAIL byp_rs1 got=%h exp=12345678", D_REG_S1_V); end
    tick;
    W_VALID = 1'b0;
    #1;
    checks++; if (D_REG_S1_V !== 32'h12345678) begin errors++; $display("FAIL byp_persist got=%h exp=12345678", D_REG_S1_V); end
    W_VALID = 1'b1; W_REG_D = 5'd2; W_REG_D_V = 32'hCAFEF00D;
    #1;
    checks++; if (D_REG_S2_V !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_rs2 got=%h exp=cafef00d", D_REG_S2_V); end
    tick;
    W_REG_D = 5'd0; W_REG_D_V = 32'hDEADBEEF;
    #1;
    checks++; if (D_REG_S1_V !== 32'h12345678) begin errors++; $display("FAIL byp_x0_rs1 got=%h exp=12345678", D_REG_S1_V); end
    checks++; if (D_REG_S2_V !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_x0_rs2 got=%h exp=cafef00d", D_REG_S2_V); end
    STALL = 1'b0; F_INST = 32'h00500093;
    tick;
    checks++; if (D_REG_S1_V !== 32'h0) begin errors++; $display("FAIL byp_x0_read got=%h exp=0", D_REG_S1_V); end
    W_VALID = 1'b0;
    // lui: raw rs1 field is 8 but the operand is absent, so no forwarding
    F_INST = 32'h123452B7;
    tick;
    W_VALID = 1'b1; W_REG_D = 5'd8; W_REG_D_V = 32'h88;
    #1;
    checks++; if (D_REG_S1_V !== 32'h0) begin errors++; $display("FAIL byp_gated got=%h exp=0", D_REG_S1_V); end
    tick;
    W_VALID = 1'b0;
  endtask

  task automatic test_formats;
    logic [31:0] insts [10];
    logic [31:0] imms  [10];
    logic [4:0]  rds   [10];
    logic [4:0]  rs1s  [10];
    logic [4:0]  rs2s  [10];
    insts[0] = 32'h002081B3; imms[0] = 32'h0;        rds[0] = 5'd3;  rs1s[0] = 5'd1; rs2s[0] = 5'd2;
    insts[1] = 32'h402081B3; imms[1] = 32'h0;        rds[1] = 5'd3;  rs1s[1] = 5'd1; rs2s[1] = 5'd2;
    insts[2] = 32'h00812183; imms[2] = 32'h8;        rds[2] = 5'd3;  rs1s[2] = 5'd2; rs2s[2] = 5'd0;
    insts[3] = 32'h00008067; imms[3] = 32'h0;        rds[3] = 5'd0;  rs1s[3] = 5'd1; rs2s[3] = 5'd0;
    insts[4] = 32'hFE208CE3; imms[4] = 32'hFFFFFFF8; rds[4] = 5'd0;  rs1s[4] = 5'd1; rs2s[4] = 5'd2;
    insts[5] = 32'h123452B7; imms[5] = 32'h12345000; rds[5] = 5'd5;  rs1s[5] = 5'd0; rs2s[5] = 5'd0;
    insts[6] = 32'hFFFFF517; imms[6] = 32'hFFFFF000; rds[6] = 5'd10; rs1s[6] = 5'd0; rs2s[6] = 5'd0;
    insts[7] = 32'hFFDFF0EF; imms[7] = 32'hFFFFFFFC; rds[7] = 5'd1;  rs1s[7] = 5'd0; rs2s[7] = 5'd0;
    insts[8] = 32'h00000073; imms[8] = 32'h0;        rds[8] = 5'd0;  rs1s[8] = 5'd0; rs2s[8] = 5'd0;
    insts[9] = 32'h0FF0000F; imms[9] = 32'h0;        rds[9] = 5'd0;  rs1s[9] = 5'd0; rs2s[9] = 5'd0;
    F_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      F_INST = insts[i];
      F_PC   = 32'h1000 + 4 * i;
      tick;
      checks++; if (D_INST !== insts[i]) begin errors++; $display("FAIL fmt%0d_inst got=%h exp=%h", i, D_INST, insts[i]); end
      checks++; if (D_IMM !== imms[i]) begin errors++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, D_IMM, imms[i]); end
      checks++; if (D_REG_D !== rds[i]) begin errors++; $display("FAIL fmt%0d_rd got=%0d exp=%0d", i, D_REG_D, rds[i]); end
      checks++; if (D_REG_S1 !== rs1s[i]) begin errors++; $display("FAIL fmt%0d_rs1 got=%0d exp=%0d", i, D_REG_S1, rs1s[i]); end
      checks++; if (D_REG_S2 !== rs2s[i]) begin errors++; $display("FAIL fmt%0d_rs2 got=%0d exp=%0d", i, D_REG_S2, rs2s[i]); end
    end
    checks++; if (D_FUNCT7 !== 7'h07) begin errors++; $display("FAIL fence_funct7 got=%h exp=07", D_FUNCT7); end
    checks++; if (D_OPCODE !== 7'h0F) begin errors++; $display("FAIL fence_opcode got=%h exp=0f", D_OPCODE); end
  endtask

  task automatic test_stall_flush;
    STALL = 1'b0; FLUSH = 1'b0;
    F_PC = 32'h300; F_INST = 32'h002081B3; F_VALID = 1'b1;
    tick;
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      F_PC = 32'h400 + 4 * i; F_INST = 32'h00000100 + i; F_VALID = i[0];
      tick;
      checks++; if (D_PC !== 32'h300) begin errors++; $display("FAIL stall%0d_pc got=%h exp=00000300", i, D_PC); end
      checks++; if (D_INST !== 32'h002081B3) begin errors++; $display("FAIL stall%0d_inst got=%h exp=002081b3", i, D_INST); end
      checks++; if (D_VALID !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got=%0b exp=1", i, D_VALID); end
    end
    FLUSH = 1'b1; F_VALID = 1'b1;
    tick;
    checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", D_VALID); end
    FLUSH = 1'b0; STALL = 1'b0; F_INST = 32'h00000013; F_PC = 32'h500;
    tick;
    checks++; if (D_VALID !== 1'b1) begin errors++; $display("FAIL flush_recover got=%0b exp=1", D_VALID); end
    checks++; if (D_PC !== 32'h500) begin errors++; $display("FAIL flush_recover_pc got=%h exp=00000500", D_PC); end
  endtask

  task automatic test_reset_mid;
    W_VALID = 1'b1; W_REG_D = 5'd5; W_REG_D_V = 32'h77;
    tick;
    W_REG_D_V = 32'h55; RST = 1'b0;
    tick;
    RST = 1'b1; W_VALID = 1'b0;
    checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", D_VALID); end
    F_INST = {7'b0, 5'd1, 5'd5, 3'b000, 5'd0, 7'b0110011};
    F_VALID = 1'b1;
    tick;
    checks++; if (D_REG_S1_V !== 32'h0) begin errors++; $display("FAIL rstmid_x5 got=%h exp=0", D_REG_S1_V); end
    checks++; if (D_REG_S2_V !== 32'h0) begin errors++; $display("FAIL rstmid_x1 got=%h exp=0", D_REG_S2_V); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_store;
    test_bypass;
    test_formats;
    test_stall_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
